// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: in-order fetch with a PC-tagged FIFO to decode and redirect flush (optional FETCH_PERF_CNT_EN perf counters)
module instruction_fetch_queue #(
  parameter int PC_WIDTH = 8,
  parameter int INST_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [PC_WIDTH-1:0]   inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [7:0]            flush_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] SLOTS = (CW+1)'(DEPTH);
  logic [PC_WIDTH-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [INST_WIDTH-1:0] data_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem [DEPTH];
  logic resp, push, pop;
  // responses with nothing outstanding are stale leftovers from before reset
  assign resp = imem_rvalid && (outstanding != '0);
  assign push = resp && (drop_cnt == '0) && !redirect_valid;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  assign imem_req = reset && !redirect_valid && ({1'b0, count} + {1'b0, outstanding} < SLOTS);
  assign imem_addr = fetch_pc;
  assign inst_valid = count != '0;
  assign inst_data = data_mem[rd_ptr];
  assign inst_pc = pc_mem[rd_ptr];
  // fetch/response PCs, occupancy, in-flight and drop bookkeeping; redirect overrides all
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      outstanding <= outstanding + CW'(imem_req) - CW'(resp);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc <= redirect_pc;
        drop_cnt <= outstanding - CW'(resp);
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) resp_pc <= resp_pc + PC_WIDTH'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr] <= resp_pc;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  // saturating stall and flush counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!inst_valid && !redirect_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
      if (redirect_valid && flush_count != '1) flush_count <= flush_count + 8'd1;
    end
  end
`endif
endmodule
